key_scan: RTL and testbench



---
 rtl/key_scan_pkg.sv | 19 +
 rtl/key_debounce.sv | 140 ++++++++++++++
 rtl/key_scan.sv | 64 ++++++
 tb/tb_key_scan.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_scan_pkg.sv
// ---------------------------------------------------------------------------
// key_scan_pkg
// Shared types and constants for the push-button front end.
//   NKEY      : number of user push-buttons handled by key_scan
//   key_st_e  : per-key debounce / auto-repeat state
// ---------------------------------------------------------------------------
package key_scan_pkg;

   localparam int NKEY = 4;

   typedef enum logic [2:0] {
      IDLE,
      PRESS_DEB,
      HELD,
      REPEAT,
      REL_DEB
   } key_st_e;

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// One push-button: 2-flop synchroniser, debounce FSM and auto-repeat timer.
// Ports:
//   CLK_i        system clock
//   RST_i        synchronous active-high reset
//   key_raw_i    raw pin, asynchronous to CLK_i
//   key_o        registered one-cycle pulse per qualified press or repeat
//   key_next_o   value key_o takes at the next edge (lets the parent register
//                an aggregate in the same cycle as key_o)
//   key_level_o  registered debounced level, 1 = pressed
//   key_long_o   registered, 1 while in REPEAT
// ---------------------------------------------------------------------------
module key_debounce
   import key_scan_pkg::*;
#(
   parameter logic [31:0] DEB_CNT        = 32'd999_999,
   parameter logic [31:0] LONG_CNT       = 32'd49_999_999,
   parameter logic [31:0] REPEAT_CNT     = 32'd9_999_999,
   parameter logic        REPEAT_EN      = 1'b1,
   parameter logic        KEY_ACTIVE_LOW = 1'b1
) (
   input  logic CLK_i,
   input  logic RST_i,
   input  logic key_raw_i,
   output logic key_o,
   output logic key_next_o,
   output logic key_level_o,
   output logic key_long_o
);

   logic        sync1_reg;
   logic        sync2_reg;
   logic        pressed;
   key_st_e     state_reg, state_next;
   logic [31:0] cnt_reg, cnt_next;
   logic        pulse_reg, pulse_next;
   logic        level_reg, level_next;
   logic        long_reg, long_next;

   assign pressed = sync2_reg ^ KEY_ACTIVE_LOW;

   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         // Synchroniser parks at the released level so a key held through
         // reset has to qualify again from IDLE.
         sync1_reg <= KEY_ACTIVE_LOW;
         sync2_reg <= KEY_ACTIVE_LOW;
         state_reg <= IDLE;
         cnt_reg   <= '0;
         pulse_reg <= 1'b0;
         level_reg <= 1'b0;
         long_reg  <= 1'b0;
      end else begin
         sync1_reg <= key_raw_i;
         sync2_reg <= sync1_reg;
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         pulse_reg <= pulse_next;
         level_reg <= level_next;
         long_reg  <= long_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      pulse_next = 1'b0;
      level_next = level_reg;
      long_next  = long_reg;
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (pressed) state_next = PRESS_DEB;
         end
         PRESS_DEB: begin
            if (!pressed) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt_reg == DEB_CNT - 32'd1) begin
               state_next = HELD;
               cnt_next   = '0;
               pulse_next = 1'b1;
               level_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + 32'd1;
            end
         end
         HELD: begin
            if (!pressed) begin
               state_next = REL_DEB;
               cnt_next   = '0;
            end else if (REPEAT_EN && (cnt_reg == LONG_CNT - 32'd1)) begin
               state_next = REPEAT;
               cnt_next   = '0;
               pulse_next = 1'b1;
               long_next  = 1'b1;
            end else if (cnt_reg != '1) begin
               // Saturate so a very long hold without auto-repeat never wraps.
               cnt_next = cnt_reg + 32'd1;
            end
         end
         REPEAT: begin
            if (!pressed) begin
               state_next = REL_DEB;
               cnt_next   = '0;
               long_next  = 1'b0;
            end else if (cnt_reg == REPEAT_CNT - 32'd1) begin
               pulse_next = 1'b1;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 32'd1;
            end
         end
         REL_DEB: begin
            if (pressed) begin
               // Release bounce: back to HELD without a new pulse.
               state_next = HELD;
               cnt_next   = '0;
            end else if (cnt_reg == DEB_CNT - 32'd1) begin
               state_next = IDLE;
               cnt_next   = '0;
               level_next = 1'b0;
            end else begin
               cnt_next = cnt_reg + 32'd1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign key_o       = pulse_reg;
   assign key_next_o  = pulse_next;
   assign key_level_o = level_reg;
   assign key_long_o  = long_reg;

endmodule

// File: rtl/key_scan.sv
// ---------------------------------------------------------------------------
// key_scan
// Front end for the four user push-buttons: synchronise, debounce and
// produce press / auto-repeat pulses.
// Ports:
//   CLK_i        system clock
//   RST_i        synchronous active-high reset
//   key_raw_i    raw button pins, asynchronous
//   key_o        one-cycle pulse per qualified press or repeat, per key
//   key_level_o  debounced pressed level per key
//   key_long_o   per key, 1 while auto-repeating
//   key_any_o    OR of key_o, registered so it lines up with key_o
// ---------------------------------------------------------------------------
module key_scan
   import key_scan_pkg::*;
#(
   parameter logic [31:0] DEB_CNT        = 32'd999_999,
   parameter logic [31:0] LONG_CNT       = 32'd49_999_999,
   parameter logic [31:0] REPEAT_CNT     = 32'd9_999_999,
   parameter logic        REPEAT_EN      = 1'b1,
   parameter logic        KEY_ACTIVE_LOW = 1'b1
) (
   input  logic            CLK_i,
   input  logic            RST_i,
   input  logic [NKEY-1:0] key_raw_i,
   output logic [NKEY-1:0] key_o,
   output logic [NKEY-1:0] key_level_o,
   output logic [NKEY-1:0] key_long_o,
   output logic            key_any_o
);

   logic [NKEY-1:0] pulse_next;
   logic            any_reg;

   generate
      for (genvar gi = 0; gi < NKEY; gi++) begin : g_key
         key_debounce #(
            .DEB_CNT        (DEB_CNT),
            .LONG_CNT       (LONG_CNT),
            .REPEAT_CNT     (REPEAT_CNT),
            .REPEAT_EN      (REPEAT_EN),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
         ) u_deb (
            .CLK_i       (CLK_i),
            .RST_i       (RST_i),
            .key_raw_i   (key_raw_i[gi]),
            .key_o       (key_o[gi]),
            .key_next_o  (pulse_next[gi]),
            .key_level_o (key_level_o[gi]),
            .key_long_o  (key_long_o[gi])
         );
      end
   endgenerate

   // Registered from the per-key next-pulse values so it is high in exactly
   // the same cycle as the key_o bits it summarises.
   always_ff @(posedge CLK_i) begin
      if (RST_i) any_reg <= 1'b0;
      else       any_reg <= |pulse_next;
   end

   assign key_any_o = any_reg;

endmodule

// File: tb/tb_key_scan.sv
module tb_key_scan;

   typedef logic [36:0] ev_t;   // {cycle[31:0], key_o[3:0], key_any_o}

   logic       clk;
   logic       rst;
   logic [3:0] raw, raw_nr;
   logic [3:0] key_o, key_level_o, key_long_o;
   logic       key_any_o;
   logic [3:0] nr_key_o, nr_level_o, nr_long_o;
   logic       nr_any_o;

   int  cyc = 0;
   int  pass_cnt = 0;
   int  total_cnt = 0;
   ev_t exp_q[$], obs_q[$], exp_nr_q[$], obs_nr_q[$];
   logic nr_long_seen = 1'b0;

   key_scan #(
      .DEB_CNT(32'd4), .LONG_CNT(32'd20), .REPEAT_CNT(32'd6),
      .REPEAT_EN(1'b1), .KEY_ACTIVE_LOW(1'b1)
   ) dut (
      .CLK_i(clk), .RST_i(rst), .key_raw_i(raw),
      .key_o(key_o), .key_level_o(key_level_o),
      .key_long_o(key_long_o), .key_any_o(key_any_o)
   );

   key_scan #(
      .DEB_CNT(32'd4), .LONG_CNT(32'd20), .REPEAT_CNT(32'd6),
      .REPEAT_EN(1'b0), .KEY_ACTIVE_LOW(1'b1)
   ) dut_nr (
      .CLK_i(clk), .RST_i(rst), .key_raw_i(raw_nr),
      .key_o(nr_key_o), .key_level_o(nr_level_o),
      .key_long_o(nr_long_o), .key_any_o(nr_any_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cyc = number of the most recent rising edge
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: every non-idle cycle becomes an observed event
   always @(negedge clk) begin
      if (key_o != 4'b0 || key_any_o)
         obs_q.push_back({32'(cyc), key_o, key_any_o});
      if (nr_key_o != 4'b0 || nr_any_o)
         obs_nr_q.push_back({32'(cyc), nr_key_o, nr_any_o});
      if (nr_long_o != 4'b0) nr_long_seen = 1'b1;
   end

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; raw = 4'hF; raw_nr = 4'hF;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({key_o, key_level_o, key_long_o, key_any_o} !== 13'b0)
         $display("FAIL reset_outputs: got %h required 0", {key_o, key_level_o, key_long_o, key_any_o});
      else pass_cnt++;
      rst = 1'b0;
      repeat (8) @(negedge clk);
      total_cnt++;
      if ({key_o, key_level_o, key_long_o, key_any_o, nr_key_o, nr_level_o} !== 21'b0)
         $display("FAIL idle_after_reset: got %h required 0", {key_o, key_level_o, key_long_o, key_any_o, nr_key_o, nr_level_o});
      else pass_cnt++;
      obs_q.delete(); obs_nr_q.delete();
   endtask

   task automatic test_clean_press();
      int c; ev_t o, e;
      @(negedge clk); c = cyc;
      raw[0] = 1'b0;                       // first sampled at edge c+1
      exp_q.push_back({32'(c + 7),  4'b0001, 1'b1});
      exp_q.push_back({32'(c + 27), 4'b0001, 1'b1});
      exp_q.push_back({32'(c + 33), 4'b0001, 1'b1});
      exp_q.push_back({32'(c + 39), 4'b0001, 1'b1});
      wait_to(c + 6);  total_cnt++;
      if (key_level_o[0] !== 1'b0) $display("FAIL clean_level_pre: got %b required 0", key_level_o[0]); else pass_cnt++;
      wait_to(c + 7);  total_cnt++;
      if (key_level_o[0] !== 1'b1) $display("FAIL clean_level_rise: got %b required 1", key_level_o[0]); else pass_cnt++;
      wait_to(c + 26); total_cnt++;
      if (key_long_o[0] !== 1'b0) $display("FAIL clean_long_pre: got %b required 0", key_long_o[0]); else pass_cnt++;
      wait_to(c + 27); total_cnt++;
      if (key_long_o[0] !== 1'b1) $display("FAIL clean_long_rise: got %b required 1", key_long_o[0]); else pass_cnt++;
      wait_to(c + 40);
      raw[0] = 1'b1;                       // release sampled at edge c+41
      wait_to(c + 42); total_cnt++;
      if (key_long_o[0] !== 1'b1) $display("FAIL clean_long_hold: got %b required 1", key_long_o[0]); else pass_cnt++;
      wait_to(c + 43); total_cnt++;
      if (key_long_o[0] !== 1'b0) $display("FAIL clean_long_fall: got %b required 0", key_long_o[0]); else pass_cnt++;
      wait_to(c + 46); total_cnt++;
      if (key_level_o[0] !== 1'b1) $display("FAIL clean_level_hold: got %b required 1", key_level_o[0]); else pass_cnt++;
      wait_to(c + 47); total_cnt++;
      if (key_level_o[0] !== 1'b0) $display("FAIL clean_level_fall: got %b required 0", key_level_o[0]); else pass_cnt++;
      wait_to(c + 55);
      total_cnt++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL clean_pulse_count: got %0d required %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); total_cnt++;
         if (o !== e) $display("FAIL clean_pulse: got cyc=%0d key=%b any=%b required cyc=%0d key=%b any=%b", o[36:5], o[4:1], o[0], e[36:5], e[4:1], e[0]);
         else pass_cnt++;
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_bounce();
      int c; int lvl_hi = 0;
      @(negedge clk); c = cyc;
      raw[1] = 1'b0;                       // low for edges c+1..c+3
      wait_to(c + 3); raw[1] = 1'b1;       // high for edges c+4..c+5
      wait_to(c + 5); raw[1] = 1'b0;       // low for edges c+6..c+7
      wait_to(c + 7); raw[1] = 1'b1;
      while (cyc < c + 20) begin
         if (key_level_o[1]) lvl_hi++;
         @(negedge clk);
      end
      total_cnt++;
      if (lvl_hi !== 0) $display("FAIL bounce_level: got %0d high cycles required 0", lvl_hi); else pass_cnt++;
      total_cnt++;
      if (obs_q.size() !== 0) $display("FAIL bounce_pulse_count: got %0d required 0", obs_q.size()); else pass_cnt++;
      obs_q.delete();
   endtask

   task automatic test_release_bounce();
      int c; ev_t o, e;
      @(negedge clk); c = cyc;
      // Held 15 clocks: short enough that no auto-repeat occurs, so the
      // release bounce is the only thing that could create an extra pulse.
      raw[2] = 1'b0;
      exp_q.push_back({32'(c + 7), 4'b0100, 1'b1});
      wait_to(c + 15); raw[2] = 1'b1;      // released edges c+16..c+17
      wait_to(c + 17); raw[2] = 1'b0;      // pressed edges c+18..c+20
      wait_to(c + 19); total_cnt++;
      if (key_level_o[2] !== 1'b1) $display("FAIL relb_level_bounce: got %b required 1", key_level_o[2]); else pass_cnt++;
      wait_to(c + 20); raw[2] = 1'b1;      // final release sampled at c+21
      wait_to(c + 26); total_cnt++;
      if (key_level_o[2] !== 1'b1) $display("FAIL relb_level_hold: got %b required 1", key_level_o[2]); else pass_cnt++;
      wait_to(c + 27); total_cnt++;
      if (key_level_o[2] !== 1'b0) $display("FAIL relb_level_fall: got %b required 0", key_level_o[2]); else pass_cnt++;
      wait_to(c + 35);
      total_cnt++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL relb_pulse_count: got %0d required %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); total_cnt++;
         if (o !== e) $display("FAIL relb_pulse: got cyc=%0d key=%b any=%b required cyc=%0d key=%b any=%b", o[36:5], o[4:1], o[0], e[36:5], e[4:1], e[0]);
         else pass_cnt++;
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_simultaneous();
      int c; ev_t o, e;
      @(negedge clk); c = cyc;
      raw[0] = 1'b0; raw[3] = 1'b0;
      exp_q.push_back({32'(c + 7), 4'b1001, 1'b1});
      wait_to(c + 8); raw[0] = 1'b1; raw[3] = 1'b1;
      wait_to(c + 22);
      total_cnt++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL simul_pulse_count: got %0d required %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); total_cnt++;
         if (o !== e) $display("FAIL simul_pulse: got cyc=%0d key=%b any=%b required cyc=%0d key=%b any=%b", o[36:5], o[4:1], o[0], e[36:5], e[4:1], e[0]);
         else pass_cnt++;
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_mid_hold();
      int c; ev_t o, e;
      @(negedge clk); c = cyc;
      raw[1] = 1'b0;
      exp_q.push_back({32'(c + 7),  4'b0010, 1'b1});
      exp_q.push_back({32'(c + 27), 4'b0010, 1'b1});
      wait_to(c + 28); total_cnt++;
      if (key_long_o[1] !== 1'b1) $display("FAIL rst_long_before: got %b required 1", key_long_o[1]); else pass_cnt++;
      wait_to(c + 29); rst = 1'b1;         // reset edges c+30..c+32
      wait_to(c + 30); total_cnt++;
      if ({key_o, key_level_o, key_long_o, key_any_o} !== 13'b0)
         $display("FAIL rst_outputs_0: got %h required 0", {key_o, key_level_o, key_long_o, key_any_o});
      else pass_cnt++;
      wait_to(c + 32); total_cnt++;
      if ({key_o, key_level_o, key_long_o, key_any_o} !== 13'b0)
         $display("FAIL rst_outputs_1: got %h required 0", {key_o, key_level_o, key_long_o, key_any_o});
      else pass_cnt++;
      rst = 1'b0;                          // first live sample at edge c+33
      exp_q.push_back({32'(c + 39), 4'b0010, 1'b1});
      wait_to(c + 38); total_cnt++;
      if (key_level_o[1] !== 1'b0) $display("FAIL rst_requal_pre: got %b required 0", key_level_o[1]); else pass_cnt++;
      wait_to(c + 39); total_cnt++;
      if (key_level_o[1] !== 1'b1) $display("FAIL rst_requal_level: got %b required 1", key_level_o[1]); else pass_cnt++;
      wait_to(c + 45); raw[1] = 1'b1;
      wait_to(c + 58);
      total_cnt++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL rst_pulse_count: got %0d required %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); total_cnt++;
         if (o !== e) $display("FAIL rst_pulse: got cyc=%0d key=%b any=%b required cyc=%0d key=%b any=%b", o[36:5], o[4:1], o[0], e[36:5], e[4:1], e[0]);
         else pass_cnt++;
      end
      obs_q.delete(); exp_q.delete(); obs_nr_q.delete();
   endtask

   task automatic test_no_repeat();
      int c; ev_t o, e;
      @(negedge clk); c = cyc;
      nr_long_seen = 1'b0;
      raw_nr[0] = 1'b0;
      exp_nr_q.push_back({32'(c + 7), 4'b0001, 1'b1});
      wait_to(c + 50); total_cnt++;
      if (nr_level_o[0] !== 1'b1) $display("FAIL norep_level: got %b required 1", nr_level_o[0]); else pass_cnt++;
      wait_to(c + 100); raw_nr[0] = 1'b1;
      wait_to(c + 112); total_cnt++;
      if (nr_level_o[0] !== 1'b0) $display("FAIL norep_level_fall: got %b required 0", nr_level_o[0]); else pass_cnt++;
      total_cnt++;
      if (nr_long_seen !== 1'b0) $display("FAIL norep_long: got %b required 0", nr_long_seen); else pass_cnt++;
      total_cnt++;
      if (obs_nr_q.size() !== exp_nr_q.size()) $display("FAIL norep_pulse_count: got %0d required %0d", obs_nr_q.size(), exp_nr_q.size()); else pass_cnt++;
      while (obs_nr_q.size() > 0 && exp_nr_q.size() > 0) begin
         o = obs_nr_q.pop_front(); e = exp_nr_q.pop_front(); total_cnt++;
         if (o !== e) $display("FAIL norep_pulse: got cyc=%0d key=%b any=%b required cyc=%0d key=%b any=%b", o[36:5], o[4:1], o[0], e[36:5], e[4:1], e[0]);
         else pass_cnt++;
      end
      obs_nr_q.delete(); exp_nr_q.delete();
   endtask

   initial begin
      rst = 1'b1; raw = 4'hF; raw_nr = 4'hF;
      test_reset();
      test_clean_press();
      test_bounce();
      test_release_bounce();
      test_simultaneous();
      test_reset_mid_hold();
      test_no_repeat();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
